pipeline_if_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register, directly upstream of pipeline_ID.
//  - Holds the PC and presents it to the external combinational instruction ROM.
//  - Registers {ID_PC, ID_instruction} for the decode stage.
//  - Applies decode-stage redirects (branch, jump, jr, interrupt, exception) with a one-cycle flush.
//  - Holds fetch and the IF/ID register on a load-use stall.

---
 rtl/pipeline_if_stage.sv | 102 ++++++++++
 tb/tb_pipeline_if_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: PC sequencing, decode-stage
// redirects with a one-bubble squash, and load-use stall hold.
module pipeline_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
    parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IF_stall,
    input  logic [2:0]  PCSrc,
    input  logic        IDcontrol_Branch,
    input  logic [31:0] ConBA,
    input  logic [25:0] JT,
    input  logic [31:0] PCout,
    output logic [31:0] IF_PC,
    input  logic [31:0] IM_instruction,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_instruction,
    output logic        IF_flush
);

    localparam logic [2:0] SRC_SEQ    = 3'd0;
    localparam logic [2:0] SRC_BRANCH = 3'd1;
    localparam logic [2:0] SRC_JUMP   = 3'd2;
    localparam logic [2:0] SRC_JR     = 3'd3;
    localparam logic [2:0] SRC_ILLOP  = 3'd4;
    localparam logic [2:0] SRC_XADR   = 3'd5;

    logic [31:0] if_pc_r;
    logic [31:0] id_pc_r;
    logic [31:0] id_instr_r;
    logic [31:0] seq_pc_s;
    logic [31:0] target_s;
    logic        redirect_req_s;
    logic        redirect_s;

    // Sequential PC: the kernel bit is preserved, only the low 31 bits increment and wrap.
    always_comb begin
        seq_pc_s = {if_pc_r[31], if_pc_r[30:0] + 31'd4};
    end

    // Decode whether the ID stage requests a redirect; codes 6/7 behave as sequential.
    always_comb begin
        redirect_req_s = 1'b0;
        case (PCSrc)
            SRC_SEQ:    redirect_req_s = 1'b0;
            SRC_BRANCH: redirect_req_s = IDcontrol_Branch;
            SRC_JUMP:   redirect_req_s = 1'b1;
            SRC_JR:     redirect_req_s = 1'b1;
            SRC_ILLOP:  redirect_req_s = 1'b1;
            SRC_XADR:   redirect_req_s = 1'b1;
            default:    redirect_req_s = 1'b0;
        endcase
    end

    // A stall keeps the branch/jump in ID, so the redirect is deferred rather than taken.
    always_comb begin
        redirect_s = redirect_req_s & ~IF_stall;
    end

    // Redirect target; the jump region comes from the PC of the jump held in ID.
    always_comb begin
        target_s = seq_pc_s;
        case (PCSrc)
            SRC_BRANCH: target_s = ConBA;
            SRC_JUMP:   target_s = {id_pc_r[31:28], JT, 2'b00};
            SRC_JR:     target_s = PCout;
            SRC_ILLOP:  target_s = ILLOP_PC;
            SRC_XADR:   target_s = XADR_PC;
            default:    target_s = seq_pc_s;
        endcase
    end

    // PC and IF/ID register update: reset > stall > redirect > sequential.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_pc_r    <= RESET_PC;
            id_pc_r    <= RESET_PC;
            id_instr_r <= 32'h0000_0000;
        end else if (IF_stall) begin
            if_pc_r    <= if_pc_r;
            id_pc_r    <= id_pc_r;
            id_instr_r <= id_instr_r;
        end else if (redirect_s) begin
            // The bubble still carries a valid return address for an interrupt taken on it.
            if_pc_r    <= target_s;
            id_pc_r    <= seq_pc_s;
            id_instr_r <= 32'h0000_0000;
        end else begin
            if_pc_r    <= seq_pc_s;
            id_pc_r    <= seq_pc_s;
            id_instr_r <= IM_instruction;
        end
    end

    assign IF_PC          = if_pc_r;
    assign ID_PC          = id_pc_r;
    assign ID_instruction = id_instr_r;
    assign IF_flush       = redirect_s;

endmodule

// File: tb/tb_pipeline_if_stage.sv
// Directed self-checking bench for pipeline_if_stage; the ROM returns ~address so every
// fetched word is hand-predictable.
module tb_pipeline_if_stage;

    logic        clk;
    logic        reset;
    logic        IF_stall;
    logic [2:0]  PCSrc;
    logic        IDcontrol_Branch;
    logic [31:0] ConBA;
    logic [25:0] JT;
    logic [31:0] PCout;
    logic [31:0] IF_PC;
    logic [31:0] IM_instruction;
    logic [31:0] ID_PC;
    logic [31:0] ID_instruction;
    logic        IF_flush;

    int tests_run = 0;
    int tests_failed = 0;

    pipeline_if_stage dut (
        .clk(clk),
        .reset(reset),
        .IF_stall(IF_stall),
        .PCSrc(PCSrc),
        .IDcontrol_Branch(IDcontrol_Branch),
        .ConBA(ConBA),
        .JT(JT),
        .PCout(PCout),
        .IF_PC(IF_PC),
        .IM_instruction(IM_instruction),
        .ID_PC(ID_PC),
        .ID_instruction(ID_instruction),
        .IF_flush(IF_flush)
    );

    assign IM_instruction = ~IF_PC;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc,
                               input logic [31:0] idpc, input logic [31:0] instr);
        check_eq({tag, ".IF_PC"}, IF_PC, pc);
        check_eq({tag, ".ID_PC"}, ID_PC, idpc);
        check_eq({tag, ".ID_instr"}, ID_instruction, instr);
    endtask

    task automatic idle();
        IF_stall = 1'b0;
        PCSrc = 3'd0;
        IDcontrol_Branch = 1'b0;
        ConBA = 32'h0;
        JT = 26'h0;
        PCout = 32'h0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step();
        // 1: reset and first fetch
        #1 check_eq("rst_flush", {31'd0, IF_flush}, 32'd0);
        check_state("rst", 32'h8000_0000, 32'h8000_0000, 32'h0);
        reset = 1'b0;
        step();
        check_state("fetch0", 32'h8000_0004, 32'h8000_0004, 32'h7FFF_FFFF);

        // 2: taken and not-taken branch
        PCSrc = 3'd1; IDcontrol_Branch = 1'b1; ConBA = 32'h8000_0040;
        #1 check_eq("br_flush", {31'd0, IF_flush}, 32'd1);
        step();
        check_state("br_taken", 32'h8000_0040, 32'h8000_0008, 32'h0);
        IDcontrol_Branch = 1'b0;
        #1 check_eq("br_nt_flush", {31'd0, IF_flush}, 32'd0);
        step();
        check_state("br_nt", 32'h8000_0044, 32'h8000_0044, 32'h7FFF_FFBF);

        // 3: jump, jr into user mode, jump region taken from ID_PC
        idle(); PCSrc = 3'd2; JT = 26'h10;
        step();
        check_state("j_kern", 32'h8000_0040, 32'h8000_0048, 32'h0);
        idle(); PCSrc = 3'd3; PCout = 32'h0000_0100;
        step();
        check_state("jr_user", 32'h0000_0100, 32'h8000_0044, 32'h0);
        idle();
        step();
        check_state("user_seq", 32'h0000_0104, 32'h0000_0104, 32'hFFFF_FEFF);
        PCSrc = 3'd2; JT = 26'h10;
        step();
        check_state("j_user", 32'h0000_0040, 32'h0000_0108, 32'h0);

        // 4: stall holds everything and defers a pending branch
        idle();
        step();
        check_state("pre_stall", 32'h0000_0044, 32'h0000_0044, 32'hFFFF_FFBF);
        IF_stall = 1'b1; PCSrc = 3'd1; IDcontrol_Branch = 1'b1; ConBA = 32'h8000_0100;
        for (int i = 0; i < 3; i++) begin
            #1 check_eq("stall_flush", {31'd0, IF_flush}, 32'd0);
            step();
            check_state("stall", 32'h0000_0044, 32'h0000_0044, 32'hFFFF_FFBF);
        end
        IF_stall = 1'b0;
        #1 check_eq("unstall_flush", {31'd0, IF_flush}, 32'd1);
        step();
        check_state("unstall_br", 32'h8000_0100, 32'h0000_0048, 32'h0);

        // 5: vectors, unused PCSrc codes, wrap behaviour
        idle(); PCSrc = 3'd4;
        step();
        check_state("illop", 32'h8000_0004, 32'h8000_0104, 32'h0);
        PCSrc = 3'd5;
        step();
        check_state("xadr", 32'h8000_0008, 32'h8000_0008, 32'h0);
        PCSrc = 3'd7;
        #1 check_eq("src7_flush", {31'd0, IF_flush}, 32'd0);
        step();
        check_state("src7", 32'h8000_000C, 32'h8000_000C, 32'h7FFF_FFF7);
        PCSrc = 3'd6;
        #1 check_eq("src6_flush", {31'd0, IF_flush}, 32'd0);
        step();
        check_state("src6", 32'h8000_0010, 32'h8000_0010, 32'h7FFF_FFF3);
        PCSrc = 3'd3; PCout = 32'h7FFF_FFFC;
        step();
        check_eq("jr_top", IF_PC, 32'h7FFF_FFFC);
        idle();
        step();
        check_state("wrap_user", 32'h0000_0000, 32'h0000_0000, 32'h8000_0003);
        PCSrc = 3'd3; PCout = 32'hFFFF_FFFC;
        step();
        idle();
        step();
        check_state("wrap_kern", 32'h8000_0000, 32'h8000_0000, 32'h0000_0003);

        // 6: reset beats simultaneous stall and redirect
        step();
        check_eq("pre_rst", IF_PC, 32'h8000_0004);
        reset = 1'b1; IF_stall = 1'b1; PCSrc = 3'd1; IDcontrol_Branch = 1'b1; ConBA = 32'h1234_5678;
        step();
        check_state("rst_win", 32'h8000_0000, 32'h8000_0000, 32'h0);
        reset = 1'b0; idle();
        step();
        check_state("resume", 32'h8000_0004, 32'h8000_0004, 32'h7FFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
